// File: rtl/stopwatch_timer.sv
// Stopwatch counting 00:00.00..59:59.99 on a 100 Hz time base, with run/pause/clear control.
// Optional lap-hold display freeze is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_100hz,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [23:0] time_bcd,
    output logic        running,
    output logic        overflow,
    output logic        lap_active
);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    // Per-nibble maximum, {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
    localparam logic [23:0] DigitMax = 24'h595999;

    state_e      state_q, state_d;
    logic        clk_100hz_q;
    logic        tick;
    logic        do_clear;
    logic        do_count;
    logic        carry;
    logic [23:0] count_q, count_d;
    logic        overflow_q, overflow_d;

    assign tick = clk_100hz & ~clk_100hz_q;

    always_comb begin
        state_d  = state_q;
        do_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    do_clear = 1'b1;
                end else if (start_stop) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (start_stop) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (clear) begin
                    do_clear = 1'b1;
                    state_d  = StIdle;
                end else if (start_stop) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A tick on the RUN->PAUSE edge still counts: decision uses the current state.
    assign do_count = tick && (state_q == StRun);

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        carry      = do_count;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] >= DigitMax[4*i +: 4]) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (carry) begin
            overflow_d = 1'b1;
        end
        if (do_clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            clk_100hz_q <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_100hz_q <= clk_100hz;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign running  = (state_q == StRun);
    assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        lap_active_q, lap_active_d;
    logic [23:0] disp_q, disp_d;

    // Lap only toggles in RUN; leaving RUN drops the hold so the paused count shows.
    always_comb begin
        lap_active_d = 1'b0;
        if (state_d == StRun) begin
            lap_active_d = lap_active_q ^ (lap && (state_q == StRun));
        end
        disp_d = (lap_active_d && lap_active_q) ? disp_q : count_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_active_q <= 1'b0;
            disp_q       <= '0;
        end else begin
            lap_active_q <= lap_active_d;
            disp_q       <= disp_d;
        end
    end

    assign time_bcd   = disp_q;
    assign lap_active = lap_active_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign time_bcd   = count_q;
    assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed self-checking bench for stopwatch_timer; lap-hold checks follow STOPWATCH_LAP_HOLD_EN.
module tb_stopwatch_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_100hz = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [23:0] time_bcd;
    logic        running;
    logic        overflow;
    logic        lap_active;

    int total = 0;
    int bad = 0;

    stopwatch_timer dut (
        .clk        (clk),
        .rst        (rst),
        .clk_100hz  (clk_100hz),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .time_bcd   (time_bcd),
        .running    (running),
        .overflow   (overflow),
        .lap_active (lap_active)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Each tick is one clk with clk_100hz high then one with it low.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) clk_100hz = 1'b1;
            @(negedge clk) clk_100hz = 1'b0;
        end
    endtask

    task automatic pulse(input logic ss, input logic cl, input logic lp);
        @(negedge clk);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic test_reset;
        ticks(1);
        total++;
        if (time_bcd !== 24'h000000 || running !== 1'b0 || overflow !== 1'b0 || lap_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got time=%h run=%b ovf=%b lap=%b want 000000/0/0/0",
                     time_bcd, running, overflow, lap_active);
        end
        @(negedge clk) rst = 1'b0;
        ticks(3);
        total++;
        if (time_bcd !== 24'h000000 || running !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_count: got time=%h run=%b want 000000/0", time_bcd, running);
        end
    endtask

    task automatic test_count;
        pulse(1'b1, 1'b0, 1'b0);
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL start_run: got running=%b want 1", running);
        end
        ticks(150);
        total++;
        if (time_bcd !== 24'h000150 || running !== 1'b1) begin
            bad++;
            $display("FAIL count_150: got time=%h run=%b want 000150/1", time_bcd, running);
        end
        ticks(5850);
        total++;
        if (time_bcd !== 24'h010000) begin
            bad++;
            $display("FAIL count_6000: got time=%h want 010000", time_bcd);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        total++;
        if (time_bcd !== 24'h000000 || running !== 1'b0) begin
            bad++;
            $display("FAIL pause_clear: got time=%h run=%b want 000000/0", time_bcd, running);
        end
    endtask

    task automatic test_pause_on_tick;
        pulse(1'b1, 1'b0, 1'b0);
        ticks(9);
        total++;
        if (time_bcd !== 24'h000009) begin
            bad++;
            $display("FAIL count_9: got time=%h want 000009", time_bcd);
        end
        @(negedge clk);
        clk_100hz  = 1'b1;
        start_stop = 1'b1;
        @(negedge clk);
        clk_100hz  = 1'b0;
        start_stop = 1'b0;
        total++;
        if (time_bcd !== 24'h000010 || running !== 1'b0) begin
            bad++;
            $display("FAIL pause_with_tick: got time=%h run=%b want 000010/0", time_bcd, running);
        end
        ticks(5);
        total++;
        if (time_bcd !== 24'h000010) begin
            bad++;
            $display("FAIL paused_hold: got time=%h want 000010", time_bcd);
        end
        pulse(1'b1, 1'b0, 1'b0);
        ticks(1);
        total++;
        if (time_bcd !== 24'h000011 || running !== 1'b1) begin
            bad++;
            $display("FAIL resume: got time=%h run=%b want 000011/1", time_bcd, running);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        pulse(1'b1, 1'b0, 1'b0);
        // Preload 59:59.99 instead of spending 360k ticks getting there.
        @(negedge clk) force dut.count_q = 24'h595999;
        @(negedge clk) release dut.count_q;
        total++;
        if (time_bcd !== 24'h595999) begin
            bad++;
            $display("FAIL preload: got time=%h want 595999", time_bcd);
        end
        ticks(1);
        total++;
        if (time_bcd !== 24'h000000 || overflow !== 1'b1 || running !== 1'b1) begin
            bad++;
            $display("FAIL wrap: got time=%h ovf=%b run=%b want 000000/1/1",
                     time_bcd, overflow, running);
        end
        pulse(1'b0, 1'b1, 1'b0);
        ticks(1);
        total++;
        if (time_bcd !== 24'h000001 || overflow !== 1'b1 || running !== 1'b1) begin
            bad++;
            $display("FAIL clear_in_run: got time=%h ovf=%b run=%b want 000001/1/1",
                     time_bcd, overflow, running);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        total++;
        if (time_bcd !== 24'h000000 || overflow !== 1'b0 || running !== 1'b0) begin
            bad++;
            $display("FAIL clear_ovf: got time=%h ovf=%b run=%b want 000000/0/0",
                     time_bcd, overflow, running);
        end
    endtask

    task automatic test_both_pulses;
        pulse(1'b1, 1'b0, 1'b0);
        ticks(200);
        pulse(1'b1, 1'b0, 1'b0);
        total++;
        if (time_bcd !== 24'h000200 || running !== 1'b0) begin
            bad++;
            $display("FAIL pause_200: got time=%h run=%b want 000200/0", time_bcd, running);
        end
        pulse(1'b1, 1'b1, 1'b0);
        total++;
        if (time_bcd !== 24'h000000 || running !== 1'b0) begin
            bad++;
            $display("FAIL both_in_pause: got time=%h run=%b want 000000/0", time_bcd, running);
        end
        pulse(1'b1, 1'b1, 1'b0);
        ticks(2);
        total++;
        if (time_bcd !== 24'h000000 || running !== 1'b0) begin
            bad++;
            $display("FAIL both_in_idle: got time=%h run=%b want 000000/0", time_bcd, running);
        end
        pulse(1'b1, 1'b0, 1'b0);
        ticks(4);
        pulse(1'b1, 1'b1, 1'b0);
        total++;
        if (time_bcd !== 24'h000004 || running !== 1'b0) begin
            bad++;
            $display("FAIL both_in_run: got time=%h run=%b want 000004/0", time_bcd, running);
        end
        pulse(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_rst_mid_count;
        pulse(1'b1, 1'b0, 1'b0);
        ticks(742);
        total++;
        if (time_bcd !== 24'h000742) begin
            bad++;
            $display("FAIL count_742: got time=%h want 000742", time_bcd);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (time_bcd !== 24'h000000 || running !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: got time=%h run=%b want 000000/0", time_bcd, running);
        end
        ticks(2);
        @(negedge clk) rst = 1'b0;
        ticks(5);
        total++;
        if (time_bcd !== 24'h000000 || running !== 1'b0) begin
            bad++;
            $display("FAIL after_rst: got time=%h run=%b want 000000/0", time_bcd, running);
        end
    endtask

    task automatic test_lap;
`ifdef STOPWATCH_LAP_HOLD_EN
        pulse(1'b1, 1'b0, 1'b0);
        ticks(325);
        pulse(1'b0, 1'b0, 1'b1);
        ticks(100);
        total++;
        if (time_bcd !== 24'h000325 || lap_active !== 1'b1) begin
            bad++;
            $display("FAIL lap_hold: got time=%h lap=%b want 000325/1", time_bcd, lap_active);
        end
        pulse(1'b0, 1'b0, 1'b1);
        total++;
        if (time_bcd !== 24'h000425 || lap_active !== 1'b0) begin
            bad++;
            $display("FAIL lap_release: got time=%h lap=%b want 000425/0", time_bcd, lap_active);
        end
        pulse(1'b0, 1'b0, 1'b1);
        ticks(3);
        pulse(1'b1, 1'b0, 1'b0);
        total++;
        if (time_bcd !== 24'h000428 || lap_active !== 1'b0) begin
            bad++;
            $display("FAIL lap_pause: got time=%h lap=%b want 000428/0", time_bcd, lap_active);
        end
        pulse(1'b0, 1'b0, 1'b1);
        total++;
        if (lap_active !== 1'b0) begin
            bad++;
            $display("FAIL lap_in_pause: got lap=%b want 0", lap_active);
        end
        pulse(1'b0, 1'b1, 1'b0);
`else
        pulse(1'b1, 1'b0, 1'b0);
        ticks(3);
        pulse(1'b0, 1'b0, 1'b1);
        ticks(2);
        total++;
        if (time_bcd !== 24'h000005 || lap_active !== 1'b0) begin
            bad++;
            $display("FAIL lap_ignored: got time=%h lap=%b want 000005/0", time_bcd, lap_active);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_count();
        test_pause_on_tick();
        test_wrap();
        test_both_pulses();
        test_rst_mid_count();
        test_lap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
